// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline definitions: widths, opcode classes, reset PC and the fetch-entry record.
package rv32_pipe_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] AR_TYPE = 2'd0;
    localparam logic [1:0] M_TYPE  = 2'd1;
    localparam logic [1:0] BR_TYPE = 2'd2;
    localparam logic [1:0] SH_TYPE = 2'd3;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } fetch_entry_t;
endpackage

// File: rtl/rv32_fetch_queue_if.sv
// Fetch front-end bus bundle: imem request/response, EX redirect and decode handshake.
interface rv32_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    logic                       imem_req_valid;
    logic [XLEN-1:0]            imem_req_addr;
    logic                       imem_req_ready;
    logic                       imem_rsp_valid;
    logic [XLEN-1:0]            imem_rsp_data;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic                       id_valid;
    logic [XLEN-1:0]            id_ir;
    logic [XLEN-1:0]            id_npc;
    logic                       id_ready;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic                       err_rsp;

    // master: the fetch queue; slave: memory, EX and decode around it
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_ir, id_npc,
        input  id_ready,
        output occupancy, err_rsp
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_ir, id_npc,
        output id_ready,
        input  occupancy, err_rsp
    );
endinterface

// File: rtl/rv32_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with push/pop/flush; flush beats push and pop.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/rv32_fetch_queue.sv
// Fetch front end: credit-limited word fetch, in-order response buffering, redirect flush/drop.
module rv32_fetch_queue
    import rv32_pipe_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = rv32_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                RN,
    rv32_fetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding, out_nxt, drop_cnt, drop_nxt;
    logic [CW-1:0]   occ, sh_cnt;
    logic [CW:0]     in_use;
    logic            started, err_q;
    logic            req_fire, rsp_ok, q_push, q_pop;
    logic            q_full, q_empty, sh_full, sh_empty;
    logic [XLEN-1:0] sh_pc;
    fetch_entry_t    q_in, q_head;

    assign in_use   = {1'b0, occ} + {1'b0, outstanding};
    assign bus.imem_req_valid = !RN && started && !bus.redirect_valid && (in_use < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is stray: it neither pops the shadow nor enqueues
    assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
    assign q_push   = rsp_ok && (drop_cnt == '0);
    assign q_in     = '{ir: bus.imem_rsp_data, npc: sh_pc + 1'b1};

    assign bus.id_valid  = !RN && !q_empty && !bus.redirect_valid;
    assign bus.id_ir     = q_head.ir;
    assign bus.id_npc    = q_head.npc;
    assign q_pop         = bus.id_valid && bus.id_ready;
    assign bus.occupancy = occ;
    assign bus.err_rsp   = err_q;

    always_comb begin
        out_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);
        drop_nxt = drop_cnt;
        // Everything still in flight after a redirect is stale, including what was already marked
        if (bus.redirect_valid)
            drop_nxt = out_nxt;
        else if (rsp_ok && drop_cnt != '0)
            drop_nxt = drop_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            started     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
            if (bus.imem_rsp_valid && outstanding == '0)
                err_q <= 1'b1;
            if (bus.redirect_valid)
                fetch_pc <= bus.redirect_pc;
            else if (req_fire)
                fetch_pc <= fetch_pc + 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_iq (
        .clk(clk), .rst(RN), .flush(bus.redirect_valid),
        .push(q_push), .push_data(q_in), .pop(q_pop),
        .head(q_head), .count(occ), .full(q_full), .empty(q_empty)
    );

    // PC of each request in flight; popped by every counted response, dropped or not
    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_shadow (
        .clk(clk), .rst(RN), .flush(1'b0),
        .push(req_fire), .push_data(fetch_pc), .pop(rsp_ok),
        .head(sh_pc), .count(sh_cnt), .full(sh_full), .empty(sh_empty)
    );

    a_credit: assert property (@(posedge clk) disable iff (RN) in_use <= DEPTH_W);
    a_shadow: assert property (@(posedge clk) disable iff (RN)
        (sh_cnt == outstanding) && !(req_fire && sh_full) && !(rsp_ok && sh_empty));
    a_qovf:   assert property (@(posedge clk) disable iff (RN) !(q_push && q_full && !q_pop));
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed + randomized-ready bench for rv32_fetch_queue against a queue-level reference model.
module tb_rv32_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct { logic [31:0] addr; int due; bit stale; } fl_t;
    typedef struct { logic [31:0] ir; logic [31:0] npc; } ent_t;

    logic clk = 1'b0;
    logic rn;
    always #5 clk = ~clk;

    rv32_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();
    rv32_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .RN(rn), .bus(bus)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0, last_due = 0, n_acc = 0;
    bit drv_rn, drv_idr, drv_rdy, drv_redir, drv_spur;
    logic [31:0] drv_rpc;
    int drv_lat;

    fl_t  infl[$];
    ent_t mq[$], dlv[$];
    logic [31:0] m_pc = 32'h0;
    bit m_started = 0, m_err = 0;

    function automatic logic [31:0] iword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] dnpc(input int i);
        return (dlv.size() > i) ? dlv[i].npc : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] dir(input int i);
        return (dlv.size() > i) ? dlv[i].ir : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic step();
        bit exp_rv, exp_iv, acc, keep;
        fl_t f;
        ent_t e;
        @(negedge clk);
        rn = drv_rn;
        bus.id_ready       = drv_idr;
        bus.imem_req_ready = drv_rdy;
        bus.redirect_valid = drv_redir;
        bus.redirect_pc    = drv_rpc;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (!drv_rn) begin
            if (drv_spur) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hDEAD_BEEF;
            end else if (infl.size() > 0 && infl[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = iword(infl[0].addr);
            end
        end
        #1;
        exp_rv = !drv_rn && m_started && !drv_redir && (mq.size() + infl.size() < DEPTH);
        exp_iv = !drv_rn && (mq.size() != 0) && !drv_redir;
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("id_valid", bus.id_valid, exp_iv);
        if (exp_iv) begin
            chk("id_ir", bus.id_ir, mq[0].ir);
            chk("id_npc", bus.id_npc, mq[0].npc);
        end
        chk("occupancy", 32'(bus.occupancy), mq.size());
        chk("err_rsp", bus.err_rsp, m_err);

        if (bus.imem_req_valid && bus.imem_req_ready) n_acc++;
        if (bus.id_valid && drv_idr) begin
            e.ir = bus.id_ir; e.npc = bus.id_npc;
            dlv.push_back(e);
        end

        acc = exp_rv && drv_rdy;
        if (drv_rn) begin
            mq.delete(); infl.delete();
            m_pc = 32'h0; m_started = 0; m_err = 0;
        end else begin
            m_started = 1;
            keep = 0;
            if (bus.imem_rsp_valid) begin
                if (infl.size() == 0) m_err = 1;
                else begin
                    f = infl.pop_front();
                    keep = !f.stale && !drv_redir;
                end
            end
            if (drv_redir) begin
                mq.delete();
                foreach (infl[i]) infl[i].stale = 1;
                m_pc = drv_rpc;
            end else begin
                if (exp_iv && drv_idr) void'(mq.pop_front());
                if (keep) begin
                    e.ir = iword(f.addr); e.npc = f.addr + 32'd1;
                    mq.push_back(e);
                end
                if (acc) begin
                    f.addr = m_pc; f.stale = 0;
                    f.due = (cyc + drv_lat > last_due + 1) ? cyc + drv_lat : last_due + 1;
                    last_due = f.due;
                    infl.push_back(f);
                    m_pc = m_pc + 32'd1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int first_iv, max_occ;
        rn = 1'b1;
        bus.id_ready = 1'b0; bus.imem_req_ready = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        drv_rn = 1; drv_idr = 1; drv_rdy = 1; drv_redir = 0; drv_spur = 0;
        drv_rpc = 32'h0; drv_lat = 1;
        repeat (2) step();

        // Streaming, latency 1
        drv_rn = 0; dlv.delete(); first_iv = -1; max_occ = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) begin
                chk("t1_rst_req_valid", bus.imem_req_valid, 1'b0);
                chk("t1_rst_id_valid", bus.id_valid, 1'b0);
                chk("t1_rst_occ", 32'(bus.occupancy), 32'd0);
            end
            if (bus.id_valid && first_iv < 0) first_iv = k;
            if (int'(bus.occupancy) > max_occ) max_occ = bus.occupancy;
        end
        chk("t1_first_id_valid", first_iv, 32'd3);
        chk("t1_max_occ_le1", max_occ <= 1, 1'b1);
        chk("t1_npc0", dnpc(0), 32'd1);
        chk("t1_npc1", dnpc(1), 32'd2);
        chk("t1_npc2", dnpc(2), 32'd3);
        chk("t1_ir0", dir(0), iword(32'd0));

        // Decode stall fills the queue to DEPTH
        drv_rn = 1; step(); drv_rn = 0;
        drv_idr = 0; n_acc = 0;
        repeat (10) step();
        chk("t2_accepts", n_acc, 32'd4);
        chk("t2_occ_full", 32'(bus.occupancy), 32'd4);
        chk("t2_req_blocked", bus.imem_req_valid, 1'b0);
        dlv.delete(); drv_idr = 1;
        repeat (12) step();
        chk("t2_npc0", dnpc(0), 32'd1);
        chk("t2_npc1", dnpc(1), 32'd2);
        chk("t2_npc2", dnpc(2), 32'd3);
        chk("t2_npc3", dnpc(3), 32'd4);
        chk("t2_resume_npc", dnpc(4), 32'd5);

        // Redirect to 20 while a latency-3 response lands, two requests in flight
        drv_rn = 1; step(); drv_rn = 0;
        drv_lat = 3; drv_rdy = 1;
        repeat (3) step();
        drv_rdy = 0; step();
        drv_rdy = 1; drv_redir = 1; drv_rpc = 32'd20; dlv.delete();
        chk("t3_rsp_in_redirect_cycle", (infl.size() > 0 && infl[0].due <= cyc), 1'b1);
        step();
        drv_redir = 0;
        repeat (10) step();
        chk("t3_npc_after_redirect", dnpc(0), 32'd21);
        chk("t3_ir_after_redirect", dir(0), iword(32'd20));

        // PC wrap at 2^32-1
        drv_lat = 1; dlv.delete();
        drv_redir = 1; drv_rpc = 32'hFFFF_FFFF; step();
        drv_redir = 0;
        repeat (8) step();
        chk("t4_wrap_ir", dir(0), iword(32'hFFFF_FFFF));
        chk("t4_wrap_npc0", dnpc(0), 32'd0);
        chk("t4_wrap_npc1", dnpc(1), 32'd1);

        // Reset with 3 entries queued, then a stray response
        drv_idr = 0;
        for (int k = 0; k < 20 && bus.occupancy != 3; k++) step();
        chk("t5_occ_before_rst", 32'(bus.occupancy), 32'd3);
        drv_rn = 1; step(); drv_rn = 0;
        drv_spur = 1; step(); drv_spur = 0;
        chk("t5_occ_after_rst", 32'(bus.occupancy), 32'd0);
        chk("t5_idv_after_rst", bus.id_valid, 1'b0);
        step();
        chk("t5_err_set", bus.err_rsp, 1'b1);
        chk("t5_restart_valid", bus.imem_req_valid, 1'b1);
        chk("t5_restart_addr", bus.imem_req_addr, 32'd0);
        repeat (5) step();
        chk("t5_err_sticky", bus.err_rsp, 1'b1);

        // Random readiness and latency with periodic redirects
        dlv.delete();
        for (int k = 0; k < 600; k++) begin
            drv_idr   = ($urandom_range(0, 3) != 0);
            drv_rdy   = ($urandom_range(0, 3) != 0);
            drv_lat   = $urandom_range(1, 4);
            drv_redir = (k % 37 == 36);
            drv_rpc   = $urandom;
            step();
        end
        drv_redir = 0;
        chk("t6_progress", dlv.size() > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
